sdp_ram_init: RTL and testbench

SDP_RAM_INIT -- requirements
Module: sdp_ram_init

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_fill_seq.sv | 83 ++++++++
 rtl/sdp_ram_init.sv | 126 ++++++++++++
 tb/tb_sdp_ram_init.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the initialisable simple dual-port RAM.
package ram_pkg;

    // Fill sequencer states: FILL sweeps the array, READY serves user traffic.
    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } fill_state_t;

    // Read/write collision behaviour selectors for RD_MODE.
    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/ram_fill_seq.sv
// Fill sequencer: walks every address once, writing the captured fill value.
// Reset leaves it in FILL at address 0 with value 0, so the array is zeroed
// by the first sweep after reset.
module ram_fill_seq
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic [DATA_W-1:0] init_val,
    output logic              busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_val
);

    // DEPTH-1 is the all-ones address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fill_state_t       state;
    fill_state_t       state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] val_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave FILL after the last address, re-enter on init_req.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (init_req) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Sweep address and fill value; the address wraps back to 0 after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            val_q  <= '0;
        end else begin
            case (state)
                FILL: begin
                    addr_q <= addr_q + 1'b1;
                end
                READY: begin
                    if (init_req) begin
                        addr_q <= '0;
                        val_q  <= init_val;
                    end
                end
                default: begin
                    addr_q <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == FILL);
    assign fill_we   = busy;
    assign fill_addr = addr_q;
    assign fill_val  = val_q;

endmodule

// File: rtl/sdp_ram_init.sv
// Simple dual-port RAM with byte enables, selectable collision behaviour,
// optional output register and a hardware fill sweep (after reset or on request).
module sdp_ram_init
    import ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int BYTE_W  = 8,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    input  logic [DATA_W-1:0]        init_val,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBE   = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_val;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_word_merged;
    logic [DATA_W-1:0] rd_word;
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    ram_fill_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_val  (init_val),
        .busy      (busy),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_val  (fill_val)
    );

    // User traffic is accepted only in READY, and a same-cycle init_req wins.
    assign wr_fire = wr_en && !busy && !init_req;
    assign rd_fire = rd_en && !busy && !init_req;

    // Byte-merge the write data into the current contents of the target word.
    always_comb begin
        wr_word_merged = mem[wr_addr];
        for (int b = 0; b < NBE; b++) begin
            if (wr_be[b]) begin
                wr_word_merged[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read word selection, forwarding the merged write word on a write-first collision.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RD_MODE == WRITE_FIRST) && wr_fire && (rd_addr == wr_addr)) begin
            rd_word = wr_word_merged;
        end
    end

    // Array write port: the fill sweep owns the port while busy.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_addr] <= fill_val;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_word_merged;
        end
    end

    // Stage p0: registered array read; data holds when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_fire;
            if (rd_fire) begin
                data_p0 <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              vld_p1;
            logic [DATA_W-1:0] data_p1;

            // Stage p1: optional output register, advancing only on a valid p0 word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        data_p1 <= data_p0;
                    end
                end
            end

            assign rd_data  = data_p1;
            assign rd_valid = vld_p1;
        end else begin : g_no_out_reg
            assign rd_data  = data_p0;
            assign rd_valid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_init.sv
// Bench for sdp_ram_init: two instances share all inputs, one read-first with
// no output register (latency 1) and one write-first with the output register
// (latency 2), so both collision modes and both latencies are exercised.
module tb_sdp_ram_init;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic [31:0] init_val;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        busy0, busy1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdp_ram_init #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_val(init_val), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    sdp_ram_init #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_val(init_val), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [31:0] e0;   // expected read-first result
        logic [31:0] e1;   // expected write-first result
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read (with whatever write is currently driven), then check both latencies.
    task automatic rd_check(input string nm, input logic [3:0] a,
                            input logic [31:0] e0, input logic [31:0] e1);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check({nm, "_v0"}, {31'd0, rd_valid0}, 32'd1);
        check({nm, "_d0"}, rd_data0, e0);
        check({nm, "_v1early"}, {31'd0, rd_valid1}, 32'd0);
        tick();
        check({nm, "_v0low"}, {31'd0, rd_valid0}, 32'd0);
        check({nm, "_d0hold"}, rd_data0, e0);
        check({nm, "_v1"}, {31'd0, rd_valid1}, 32'd1);
        check({nm, "_d1"}, rd_data1, e1);
    endtask

    // Count busy cycles until READY; a runaway sweep counts as a failure via the count check.
    task automatic count_busy(input string nm);
        int cnt = 0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
        end
        check({nm, "_busy_cycles"}, cnt, 32'd16);
        check({nm, "_busy1_done"}, {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3,  4'b1111, 32'hDEADBEEF, 4'd3,  32'h00000000, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 4'd3,  4'b0101, 32'h11223344, 4'd3,  32'hDEADBEEF, 32'hDE22BE44};
        vecs[2] = '{1'b0, 4'd0,  4'b0000, 32'h00000000, 4'd3,  32'hDE22BE44, 32'hDE22BE44};
        vecs[3] = '{1'b1, 4'd5,  4'b1111, 32'hAAAAAAAA, 4'd5,  32'h00000000, 32'hAAAAAAAA};
        vecs[4] = '{1'b0, 4'd0,  4'b0000, 32'h00000000, 4'd5,  32'hAAAAAAAA, 32'hAAAAAAAA};
        vecs[5] = '{1'b1, 4'd5,  4'b0000, 32'hFFFFFFFF, 4'd5,  32'hAAAAAAAA, 32'hAAAAAAAA};
        vecs[6] = '{1'b1, 4'd7,  4'b1000, 32'h12345678, 4'd6,  32'h00000000, 32'h00000000};
        vecs[7] = '{1'b0, 4'd0,  4'b0000, 32'h00000000, 4'd7,  32'h12000000, 32'h12000000};
        vecs[8] = '{1'b1, 4'd15, 4'b0011, 32'hCAFEF00D, 4'd15, 32'h00000000, 32'h0000F00D};
        vecs[9] = '{1'b0, 4'd0,  4'b0000, 32'h00000000, 4'd0,  32'h00000000, 32'h00000000};

        rst = 1'b1; init_req = 1'b0; init_val = '0;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;

        // Reset state
        repeat (2) tick();
        check("rst_busy0", {31'd0, busy0}, 32'd1);
        check("rst_busy1", {31'd0, busy1}, 32'd1);
        check("rst_valid0", {31'd0, rd_valid0}, 32'd0);
        check("rst_valid1", {31'd0, rd_valid1}, 32'd0);
        check("rst_data0", rd_data0, 32'd0);
        check("rst_data1", rd_data1, 32'd0);
        rst = 1'b0;
        count_busy("post_rst");
        for (int a = 0; a < 16; a++) begin
            rd_check($sformatf("zero_a%0d", a), 4'(a), 32'd0, 32'd0);
        end

        // Directed write/read vectors
        for (int i = 0; i < 10; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_be   = vecs[i].be;
            wr_data = vecs[i].wd;
            rd_check($sformatf("vec%0d", i), vecs[i].ra, vecs[i].e0, vecs[i].e1);
        end

        // Back-to-back reads, one per cycle
        begin
            logic [3:0]  pa [3];
            logic [31:0] pe [3];
            pa[0] = 4'd3; pa[1] = 4'd5; pa[2] = 4'd7;
            pe[0] = 32'hDE22BE44; pe[1] = 32'hAAAAAAAA; pe[2] = 32'h12000000;
            for (int k = 0; k < 3; k++) begin
                rd_en   = 1'b1;
                rd_addr = pa[k];
                tick();
                check($sformatf("pipe%0d_d0", k), rd_data0, pe[k]);
                check($sformatf("pipe%0d_v0", k), {31'd0, rd_valid0}, 32'd1);
                if (k > 0) begin
                    check($sformatf("pipe%0d_d1", k), rd_data1, pe[k-1]);
                    check($sformatf("pipe%0d_v1", k), {31'd0, rd_valid1}, 32'd1);
                end
            end
            rd_en = 1'b0;
            tick();
            check("pipe_last_d1", rd_data1, pe[2]);
            check("pipe_last_v1", {31'd0, rd_valid1}, 32'd1);
            check("pipe_last_v0", {31'd0, rd_valid0}, 32'd0);
            tick();
        end

        // init_req with same-cycle write/read: write dropped, read ignored
        init_req = 1'b1; init_val = 32'h5A5A5A5A;
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        init_req = 1'b0;
        check("init_busy0", {31'd0, busy0}, 32'd1);
        check("init_busy1", {31'd0, busy1}, 32'd1);
        check("init_rd_ignored0", {31'd0, rd_valid0}, 32'd0);
        begin
            int cnt = 0;
            int vld_seen = 0;
            wr_addr = 4'd0;
            while (busy0 && cnt < 100) begin
                init_req = (cnt == 5);
                init_val = 32'h11111111;
                tick();
                cnt++;
                if (rd_valid0 || rd_valid1) vld_seen++;
            end
            init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            check("init_busy_cycles", cnt, 32'd16);
            check("init_busy1_done", {31'd0, busy1}, 32'd0);
            check("busy_rd_valid", vld_seen, 32'd0);
        end
        for (int a = 0; a < 16; a++) begin
            rd_check($sformatf("fill5a_a%0d", a), 4'(a), 32'h5A5A5A5A, 32'h5A5A5A5A);
        end

        // Reset in the middle of a sweep restarts it with value 0
        init_req = 1'b1; init_val = 32'h33333333;
        tick();
        init_req = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy0", {31'd0, busy0}, 32'd1);
        check("midrst_data0", rd_data0, 32'd0);
        check("midrst_data1", rd_data1, 32'd0);
        check("midrst_valid1", {31'd0, rd_valid1}, 32'd0);
        #1;
        rst = 1'b0;
        count_busy("midrst");
        for (int a = 0; a < 16; a++) begin
            rd_check($sformatf("refill_a%0d", a), 4'(a), 32'd0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
